fc_argmax_classifier: RTL and testbench
=======================================

# fc_argmax_classifier

Final classification stage of the CNN datapath, directly downstream of the fully-connected layer. When the FC layer signals completion, the block reads the NUM_CLASS Q-format activations from the shared activation memory, tracks the largest and second-largest values, and reports the winning class index, its score, and the top-1/top-2 margin. The margin is the confidence metric for the host.

## Interface
- NUM_CLASS, 5: number of FC outputs to scan; legal range 2..255.
- BASE_ADDR, 1: memory address of class 0; class k is at BASE_ADDR+k.
- RD_LAT, 1: memory read latency in cycles; legal range 1..3.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse, driven by the FC layer's layer_end; begins a scan.
- rd_en  out  1  memory read strobe.
- rd_addr  out  16  memory read address.
- rd_data  in  16 signed  memory read data, valid RD_LAT cycles after the rd_en cycle.
- busy  out  1  high from the cycle after start is accepted until the valid cycle, inclusive.
- valid  out  1  one-cycle pulse; result outputs are updated in this cycle.
- class_idx  out  8  index of the maximum value.
- class_max  out  16 signed  maximum value.
- second_idx  out  8  index of the second-largest value.
- margin  out  16 signed  class_max minus second value, saturated.

## Operation
- Reset values: rd_en=0, rd_addr=0, busy=0, valid=0, class_idx=0, class_max=0, second_idx=0, margin=0. The FSM goes to IDLE.
- FSM states:
  - IDLE → ISSUE on start=1.
  - ISSUE runs NUM_CLASS cycles, with rd_en=1 and rd_addr=BASE_ADDR+k on the k-th cycle.
  - ISSUE → DRAIN, where rd_en=0 while RD_LAT results are still outstanding.
  - DRAIN → DONE; DONE asserts valid and publishes results.
  - DONE → IDLE.
- Read data is tracked with an RD_LAT-deep shift register of the issued index plus a valid bit. No data is accepted without a matching issue.
- Compare rule, applied to each returned sample (index k, value v):
  - First sample: max=v, max_idx=k, second empty.
  - Otherwise, if v > max (strictly greater, signed): second←max, second_idx←max_idx, then max←v, max_idx←k.
  - Otherwise, if second is empty or v > second (strictly): second←v, second_idx←k.
  - Ties keep the lower index in both slots.
- margin = max − second, computed in 17 bits and saturated to +32767 / −32768. It is never negative in practice; saturation protects wrap-around.
- start while busy=1 is ignored. start in the DONE cycle is ignored.
- Result outputs hold their values until the next valid. Internal accumulators are cleared when a scan starts.
- Reset asserted mid-scan aborts immediately: all outputs return to their reset values and no valid is produced.
- Memory is read-only from this block. Addresses do not wrap: BASE_ADDR+NUM_CLASS−1 must be ≤ 16'hFFFF.

## Timing
- Start is sampled at the edge ending cycle S.
- rd_en is high in cycles S+1 … S+NUM_CLASS, with rd_addr=BASE_ADDR+k in cycle S+1+k.
- Sample k is captured at the edge ending cycle S+1+k+RD_LAT.
- valid is high in cycle S+NUM_CLASS+RD_LAT+1. Defaults (5, 1) give valid in S+7.
- busy is high in S+1 … S+NUM_CLASS+RD_LAT+1.
- The earliest acceptable next start is in the cycle after valid. The scan period is NUM_CLASS+RD_LAT+2 cycles.
- rd_addr holds its last value outside ISSUE. Only rd_en qualifies it.

## Test plan
- Memory at addresses 1..5 = {0x0100, 0x0500, 0x0200, 0x0300, 0x0000}, start pulse → rd_addr 1..5 in S+1..S+5; in S+7: valid=1, class_idx=1, class_max=0x0500, second_idx=3, margin=0x0200.
- Tie case {0x0600, 0x0600, 0x0100, 0x0600, 0x0000} → class_idx=0, second_idx=1, margin=0.
- Signed case {−0x0100, −0x0050, −0x0200, −0x0300, −0x0400} → class_idx=1, class_max=0xFFB0, second_idx=0, margin=0x00B0. Also verify saturation: with NUM_CLASS=2, {0x7FFF, 0x8000} → margin=0x7FFF.
- RD_LAT=3, NUM_CLASS=5 → valid at S+9, busy high S+1..S+9. A second start at S+3 is ignored; a start at S+10 runs a new scan with fresh results.
- Reset asserted at S+4 for one cycle → outputs return to 0 immediately, busy=0, no valid ever; a subsequent start completes normally.
- Monotonic increasing {1, 2, 3, 4, 5} → class_idx=4, second_idx=3, margin=1. Previous results hold unchanged between valid pulses.

Source files
------------

// File: rtl/fc_argmax_classifier.sv
// Final CNN classification stage: scans NUM_CLASS FC activations from memory and
// reports the top-1 class, its score, the runner-up index and the saturated top-1/top-2 margin.
module fc_argmax_classifier #(
  parameter int NUM_CLASS = 5,
  parameter int BASE_ADDR = 1,
  parameter int RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               rd_en,
  output logic [15:0]        rd_addr,
  input  logic signed [15:0] rd_data,
  output logic               busy,
  output logic               valid,
  output logic [7:0]         class_idx,
  output logic signed [15:0] class_max,
  output logic [7:0]         second_idx,
  output logic signed [15:0] margin
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [1:0]         dcnt_q, dcnt_d;
  logic [15:0]        addr_q, addr_d;
  logic               pipe_vld_q [RD_LAT];
  logic [7:0]         pipe_idx_q [RD_LAT];
  logic signed [15:0] max_q, max_d, sec_q, sec_d;
  logic [7:0]         max_idx_q, max_idx_d, sec_idx_q, sec_idx_d;
  logic               have_max_q, have_max_d, have_sec_q, have_sec_d;
  logic [7:0]         class_idx_q, second_idx_q;
  logic signed [15:0] class_max_q, margin_q;
  logic               start_ok, issue_last, drain_last, publish;
  logic [16:0]        diff;
  logic [15:0]        margin_sat;

  assign start_ok   = (state_q == IDLE) && start;
  assign issue_last = (cnt_q == 8'(NUM_CLASS - 1));
  assign drain_last = (dcnt_q == 2'(RD_LAT - 1));
  assign publish    = (state_q == DRAIN) && drain_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = 2'd0;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          cnt_d   = 8'd0;
          addr_d  = 16'(BASE_ADDR);
        end
      end
      ISSUE: begin
        if (issue_last) begin
          state_d = DRAIN;
        end else begin
          cnt_d  = cnt_q + 8'd1;
          addr_d = addr_q + 16'd1;
        end
      end
      DRAIN: begin
        if (drain_last) state_d = DONE;
        else            dcnt_d  = dcnt_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      dcnt_q  <= 2'd0;
      addr_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      addr_q  <= addr_d;
    end
  end

  // Each issued index rides alongside its read so returning data is only taken when matched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_idx_q[i] <= 8'd0;
      end
    end else begin
      pipe_vld_q[0] <= rd_en;
      pipe_idx_q[0] <= cnt_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  always_comb begin
    max_d      = max_q;
    max_idx_d  = max_idx_q;
    sec_d      = sec_q;
    sec_idx_d  = sec_idx_q;
    have_max_d = have_max_q;
    have_sec_d = have_sec_q;
    if (start_ok) begin
      max_d      = 16'sd0;
      max_idx_d  = 8'd0;
      sec_d      = 16'sd0;
      sec_idx_d  = 8'd0;
      have_max_d = 1'b0;
      have_sec_d = 1'b0;
    end else if (pipe_vld_q[RD_LAT-1]) begin
      // Strict comparisons keep the earlier (lower) index on ties.
      if (!have_max_q) begin
        max_d      = rd_data;
        max_idx_d  = pipe_idx_q[RD_LAT-1];
        have_max_d = 1'b1;
      end else if (rd_data > max_q) begin
        sec_d      = max_q;
        sec_idx_d  = max_idx_q;
        have_sec_d = 1'b1;
        max_d      = rd_data;
        max_idx_d  = pipe_idx_q[RD_LAT-1];
      end else if (!have_sec_q || rd_data > sec_q) begin
        sec_d      = rd_data;
        sec_idx_d  = pipe_idx_q[RD_LAT-1];
        have_sec_d = 1'b1;
      end
    end
  end

  assign diff       = {max_d[15], max_d} - {sec_d[15], sec_d};
  assign margin_sat = (diff[16] != diff[15]) ? (diff[16] ? 16'h8000 : 16'h7FFF) : diff[15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q        <= 16'sd0;
      max_idx_q    <= 8'd0;
      sec_q        <= 16'sd0;
      sec_idx_q    <= 8'd0;
      have_max_q   <= 1'b0;
      have_sec_q   <= 1'b0;
      class_idx_q  <= 8'd0;
      class_max_q  <= 16'sd0;
      second_idx_q <= 8'd0;
      margin_q     <= 16'sd0;
    end else begin
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      sec_q      <= sec_d;
      sec_idx_q  <= sec_idx_d;
      have_max_q <= have_max_d;
      have_sec_q <= have_sec_d;
      // Published on the edge entering DONE so the final sample is already folded in.
      if (publish) begin
        class_idx_q  <= max_idx_d;
        class_max_q  <= max_d;
        second_idx_q <= sec_idx_d;
        margin_q     <= margin_sat;
      end
    end
  end

  assign rd_en      = (state_q == ISSUE);
  assign rd_addr    = addr_q;
  assign busy       = (state_q != IDLE);
  assign valid      = (state_q == DONE);
  assign class_idx  = class_idx_q;
  assign class_max  = class_max_q;
  assign second_idx = second_idx_q;
  assign margin     = margin_q;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Bench for fc_argmax_classifier: three instances (default, NUM_CLASS=2, RD_LAT=3) share one
// memory model; table vectors, hand-written reset/hold sequences, then random scans vs a top-2 model.
module tb_fc_argmax_classifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        startV [3];
  logic        rdEnV [3];
  logic [15:0] rdAddrV [3];
  logic        busyV [3];
  logic        validV [3];
  logic [7:0]  classIdxV [3];
  logic [15:0] classMaxV [3];
  logic [7:0]  secondIdxV [3];
  logic [15:0] marginV [3];
  logic [15:0] mem [256];
  logic [15:0] dl [3][3];

  logic [7:0]  prevIdx [3];
  logic [15:0] prevMax [3];
  logic [7:0]  prevSec [3];
  logic [15:0] prevMargin [3];

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  fc_argmax_classifier #(.NUM_CLASS(5), .BASE_ADDR(1), .RD_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .start(startV[0]), .rd_en(rdEnV[0]), .rd_addr(rdAddrV[0]),
    .rd_data(dl[0][0]), .busy(busyV[0]), .valid(validV[0]), .class_idx(classIdxV[0]),
    .class_max(classMaxV[0]), .second_idx(secondIdxV[0]), .margin(marginV[0]));

  fc_argmax_classifier #(.NUM_CLASS(2), .BASE_ADDR(1), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(startV[1]), .rd_en(rdEnV[1]), .rd_addr(rdAddrV[1]),
    .rd_data(dl[1][0]), .busy(busyV[1]), .valid(validV[1]), .class_idx(classIdxV[1]),
    .class_max(classMaxV[1]), .second_idx(secondIdxV[1]), .margin(marginV[1]));

  fc_argmax_classifier #(.NUM_CLASS(5), .BASE_ADDR(1), .RD_LAT(3)) dut2 (
    .clk(clk), .reset(reset), .start(startV[2]), .rd_en(rdEnV[2]), .rd_addr(rdAddrV[2]),
    .rd_data(dl[2][2]), .busy(busyV[2]), .valid(validV[2]), .class_idx(classIdxV[2]),
    .class_max(classMaxV[2]), .second_idx(secondIdxV[2]), .margin(marginV[2]));

  // Memory with per-instance read delay lines; unrequested cycles return junk.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      dl[i][0] <= rdEnV[i] ? mem[rdAddrV[i][7:0]] : 16'($urandom);
      dl[i][1] <= dl[i][0];
      dl[i][2] <= dl[i][1];
    end
  end

  typedef struct {
    int          inst;
    int          n;
    logic [15:0] v [8];
    logic [7:0]  eIdx;
    logic [15:0] eMax;
    logic [7:0]  eSec;
    logic [15:0] eMargin;
    int          extra;
  } vec_t;

  vec_t tbl [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: top-1 is the first occurrence of the largest value, top-2 the first occurrence
  // of the largest among the rest; margin is their difference clamped to 16-bit signed.
  task automatic refModel(input logic [15:0] v [8], input int n, output logic [7:0] bi,
                          output logic [15:0] bm, output logic [7:0] si, output logic [15:0] mg);
    int b, s, d;
    b = 0;
    for (int k = 1; k < n; k++)
      if ($signed(v[k]) > $signed(v[b])) b = k;
    s = -1;
    for (int k = 0; k < n; k++)
      if (k != b && (s < 0 || $signed(v[k]) > $signed(v[s]))) s = k;
    d = int'($signed(v[b])) - int'($signed(v[s]));
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    bi = 8'(b);
    bm = v[b];
    si = 8'(s);
    mg = 16'(d);
  endtask

  // Starts a scan in the current cycle S (called at a negedge) and checks every cycle to S+valid+1.
  task automatic applyStimulus(input int inst, input int n, input logic [15:0] v [8],
                               input logic [7:0] eIdx, input logic [15:0] eMax,
                               input logic [7:0] eSec, input logic [15:0] eMargin,
                               input int extra, input string tag);
    int lat, vc;
    lat = (inst == 2) ? 3 : 1;
    vc  = n + lat + 1;
    for (int k = 0; k < n; k++) mem[1 + k] = v[k];
    startV[inst] = 1'b1;
    for (int c = 1; c <= vc; c++) begin
      @(negedge clk);
      startV[inst] = (c == extra);
      checkOutput($sformatf("%s rd_en c%0d", tag, c), rdEnV[inst], (c <= n));
      if (c <= n) checkOutput($sformatf("%s rd_addr c%0d", tag, c), rdAddrV[inst], 32'(c));
      checkOutput($sformatf("%s busy c%0d", tag, c), busyV[inst], 1'b1);
      checkOutput($sformatf("%s valid c%0d", tag, c), validV[inst], (c == vc));
      if (c < vc) begin
        checkOutput($sformatf("%s hold idx c%0d", tag, c), classIdxV[inst], prevIdx[inst]);
        checkOutput($sformatf("%s hold margin c%0d", tag, c), marginV[inst], prevMargin[inst]);
      end
    end
    checkOutput({tag, " class_idx"}, classIdxV[inst], eIdx);
    checkOutput({tag, " class_max"}, classMaxV[inst], eMax);
    checkOutput({tag, " second_idx"}, secondIdxV[inst], eSec);
    checkOutput({tag, " margin"}, marginV[inst], eMargin);
    prevIdx[inst]    = eIdx;
    prevMax[inst]    = eMax;
    prevSec[inst]    = eSec;
    prevMargin[inst] = eMargin;
    startV[inst] = 1'b0;
    @(negedge clk);
    checkOutput({tag, " busy after valid"}, busyV[inst], 1'b0);
    checkOutput({tag, " valid pulse width"}, validV[inst], 1'b0);
  endtask

  task automatic checkHold(input int inst, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold valid c%0d", c), validV[inst], 1'b0);
      checkOutput($sformatf("hold class_idx c%0d", c), classIdxV[inst], prevIdx[inst]);
      checkOutput($sformatf("hold class_max c%0d", c), classMaxV[inst], prevMax[inst]);
      checkOutput($sformatf("hold second_idx c%0d", c), secondIdxV[inst], prevSec[inst]);
      checkOutput($sformatf("hold margin c%0d", c), marginV[inst], prevMargin[inst]);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rd_en"}, rdEnV[0], 1'b0);
    checkOutput({tag, " rd_addr"}, rdAddrV[0], 16'h0);
    checkOutput({tag, " busy"}, busyV[0], 1'b0);
    checkOutput({tag, " valid"}, validV[0], 1'b0);
    checkOutput({tag, " class_idx"}, classIdxV[0], 8'h0);
    checkOutput({tag, " class_max"}, classMaxV[0], 16'h0);
    checkOutput({tag, " second_idx"}, secondIdxV[0], 8'h0);
    checkOutput({tag, " margin"}, marginV[0], 16'h0);
  endtask

  task automatic clearPrev();
    for (int i = 0; i < 3; i++) begin
      prevIdx[i]    = 8'h0;
      prevMax[i]    = 16'h0;
      prevSec[i]    = 8'h0;
      prevMargin[i] = 16'h0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rv [8];
    logic [7:0]  mIdx, mSec;
    logic [15:0] mMax, mMg;
    int          inst, n, seenValid;

    tbl[0] = '{0, 5, '{16'h0100, 16'h0500, 16'h0200, 16'h0300, 16'h0000, 16'h0, 16'h0, 16'h0},
               8'd1, 16'h0500, 8'd3, 16'h0200, 7};
    tbl[1] = '{0, 5, '{16'h0600, 16'h0600, 16'h0100, 16'h0600, 16'h0000, 16'h0, 16'h0, 16'h0},
               8'd0, 16'h0600, 8'd1, 16'h0000, 3};
    tbl[2] = '{0, 5, '{16'hFF00, 16'hFFB0, 16'hFE00, 16'hFD00, 16'hFC00, 16'h0, 16'h0, 16'h0},
               8'd1, 16'hFFB0, 8'd0, 16'h00B0, -1};
    tbl[3] = '{1, 2, '{16'h7FFF, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
               8'd0, 16'h7FFF, 8'd1, 16'h7FFF, -1};
    tbl[4] = '{2, 5, '{16'h000A, 16'hFFFD, 16'h0028, 16'h0028, 16'h0007, 16'h0, 16'h0, 16'h0},
               8'd2, 16'h0028, 8'd3, 16'h0000, 3};
    tbl[5] = '{2, 5, '{16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0, 16'h0, 16'h0},
               8'd0, 16'h0005, 8'd1, 16'h0001, -1};
    tbl[6] = '{0, 5, '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0, 16'h0, 16'h0},
               8'd4, 16'h0005, 8'd3, 16'h0001, -1};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) startV[i] = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    clearPrev();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkAllZero("reset state");

    for (int i = 0; i < 6; i++)
      applyStimulus(tbl[i].inst, tbl[i].n, tbl[i].v, tbl[i].eIdx, tbl[i].eMax, tbl[i].eSec,
                    tbl[i].eMargin, tbl[i].extra, $sformatf("vec%0d", i));

    // Mid-scan reset: start in S, reset pulse in S+4, then no valid must ever appear.
    for (int k = 0; k < 5; k++) mem[1 + k] = 16'h0700 + 16'(k);
    startV[0] = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkAllZero("mid-scan reset");
    clearPrev();
    @(negedge clk);
    reset = 1'b0;
    seenValid = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (validV[0] || busyV[0]) seenValid = 1;
    end
    checkOutput("no valid after reset", 32'(seenValid), 32'd0);

    applyStimulus(tbl[6].inst, tbl[6].n, tbl[6].v, tbl[6].eIdx, tbl[6].eMax, tbl[6].eSec,
                  tbl[6].eMargin, tbl[6].extra, "vec6");
    checkHold(0, 4);

    for (int r = 0; r < 24; r++) begin
      inst = int'($urandom_range(0, 2));
      n = (inst == 1) ? 2 : 5;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) rv[k] = 16'($urandom_range(0, 2)) << 14;
        else rv[k] = 16'($urandom);
      end
      refModel(rv, n, mIdx, mMax, mSec, mMg);
      applyStimulus(inst, n, rv, mIdx, mMax, mSec, mMg, -1, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
